// File: rtl/booth_r4_pp_gen.sv
// Sequential radix-4 Booth encoder: takes one signed operand pair and streams
// W/2 one's-complement partial products plus negate bits over a valid/ready handshake.
module booth_r4_pp_gen #(
  parameter int unsigned W = 8,
  localparam int unsigned NPP = W / 2,
  localparam int unsigned IW = $clog2(W / 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_mcand,
  input  logic [W-1:0]  in_mplier,
  output logic          pp_valid,
  input  logic          pp_ready,
  output logic [W:0]    pp_data,
  output logic          pp_neg,
  output logic [IW-1:0] pp_idx,
  output logic          pp_last
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NPP - 1);

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W:0]    mplier_q, mplier_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          pp_valid_q, pp_valid_d;
  logic [W:0]    pp_data_q, pp_data_d;
  logic          pp_neg_q, pp_neg_d;
  logic          pp_last_q, pp_last_d;
  logic          accept;
  logic          pp_fire;

  // Booth digit select; returns {neg, data}. Both zero triplets map to +0 so -0 never appears.
  function automatic logic [W+1:0] booth_dec(input logic [2:0] trip, input logic [W-1:0] a);
    logic [W:0] sa;
    logic [W:0] da;
    sa = {a[W-1], a};
    da = {a, 1'b0};
    case (trip)
      3'b001, 3'b010: booth_dec = {1'b0, sa};
      3'b011:         booth_dec = {1'b0, da};
      3'b100:         booth_dec = {1'b1, ~da};
      3'b101, 3'b110: booth_dec = {1'b1, ~sa};
      default:        booth_dec = '0;
    endcase
  endfunction

  // The only combinational input-to-output path: accept on the final beat to avoid a bubble.
  assign in_ready = rst_n & ((state_q == IDLE) |
                             ((state_q == EMIT) & pp_last_q & pp_ready));
  assign accept   = in_valid & in_ready;
  assign pp_fire  = pp_valid_q & pp_ready;

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    idx_d      = idx_q;
    pp_valid_d = 1'b0;
    pp_data_d  = '0;
    pp_neg_d   = 1'b0;
    pp_last_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d  = in_mcand;
          mplier_d = {in_mplier, 1'b0};
          idx_d    = '0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (pp_fire) begin
          if (pp_last_q) begin
            idx_d = '0;
            if (accept) begin
              mcand_d  = in_mcand;
              mplier_d = {in_mplier, 1'b0};
              state_d  = EMIT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d    = idx_q + IW'(1);
            mplier_d = mplier_q >> 2;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    if (state_d == EMIT) begin
      pp_valid_d             = 1'b1;
      {pp_neg_d, pp_data_d}  = booth_dec(mplier_d[2:0], mcand_d);
      pp_last_d              = (idx_d == LAST_IDX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      idx_q      <= '0;
      pp_valid_q <= 1'b0;
      pp_data_q  <= '0;
      pp_neg_q   <= 1'b0;
      pp_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      idx_q      <= idx_d;
      pp_valid_q <= pp_valid_d;
      pp_data_q  <= pp_data_d;
      pp_neg_q   <= pp_neg_d;
      pp_last_q  <= pp_last_d;
    end
  end

  assign pp_valid = pp_valid_q;
  assign pp_data  = pp_data_q;
  assign pp_neg   = pp_neg_q;
  assign pp_idx   = idx_q;
  assign pp_last  = pp_last_q;

endmodule

// File: tb/tb_booth_r4_pp_gen.sv
// Self-checking bench for booth_r4_pp_gen: directed corner pairs plus random
// pairs with random stalls, compared against an arithmetic Booth-digit model.
module tb_booth_r4_pp_gen;

  localparam int unsigned W   = 8;
  localparam int unsigned NPP = W / 2;
  localparam int unsigned IW  = $clog2(W / 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_mcand;
  logic [W-1:0]  in_mplier;
  logic          pp_valid;
  logic          pp_ready;
  logic [W:0]    pp_data;
  logic          pp_neg;
  logic [IW-1:0] pp_idx;
  logic          pp_last;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  booth_r4_pp_gen #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mcand  (in_mcand),
    .in_mplier (in_mplier),
    .pp_valid  (pp_valid),
    .pp_ready  (pp_ready),
    .pp_data   (pp_data),
    .pp_neg    (pp_neg),
    .pp_idx    (pp_idx),
    .pp_last   (pp_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Booth digit d = -2*b[2i+1] + b[2i] + b[2i-1]; partial product is d*A,
  // negatives sent as one's complement of |d|*A with the negate bit set.
  task automatic ref_beat(input logic [W-1:0] a, input logic [W-1:0] b, input int i,
                          output logic [W:0] d, output logic n);
    logic [W-1:0] bv;
    int bm1, dig, av, p;
    bv  = b;
    bm1 = (i == 0) ? 0 : int'(bv[2*i-1]);
    dig = -2 * int'(bv[2*i+1]) + int'(bv[2*i]) + bm1;
    av  = int'($signed(a));
    if (dig < 0) begin
      p = -dig * av;
      d = ~(W+1)'(p);
      n = 1'b1;
    end else begin
      p = dig * av;
      d = (W+1)'(p);
      n = 1'b0;
    end
  endtask

  // stall_mode: 0 none, 1 random 0..3 per beat, 2 three cycles at idx1
  task automatic run_seq(input bit chain, input int stall_mode);
    int n;
    logic [W-1:0] a, b;
    logic [W:0] ed;
    logic en;
    int acc, stall, pd;
    n = qa.size();
    @(negedge clk);
    in_mcand  = qa[0];
    in_mplier = qb[0];
    in_valid  = 1'b1;
    pp_ready  = 1'b0;
    #1;
    chk("in_ready_idle", in_ready, 1'b1);
    @(posedge clk);
    for (int t = 0; t < n; t++) begin
      a   = qa[t];
      b   = qb[t];
      acc = 0;
      for (int i = 0; i < int'(NPP); i++) begin
        ref_beat(a, b, i, ed, en);
        stall = (stall_mode == 1) ? int'($urandom_range(0, 3)) :
                (stall_mode == 2 && i == 1) ? 3 : 0;
        for (int s = 0; s <= stall; s++) begin
          @(negedge clk);
          chk("pp_valid", pp_valid, 1'b1);
          chk("pp_idx", pp_idx, i);
          chk("pp_data", pp_data, ed);
          chk("pp_neg", pp_neg, en);
          chk("pp_last", pp_last, (i == int'(NPP) - 1));
          pp_ready = (s == stall);
          if (i == int'(NPP) - 1 && pp_ready) begin
            if (chain && t < n - 1) begin
              in_valid  = 1'b1;
              in_mcand  = qa[t+1];
              in_mplier = qb[t+1];
            end else begin
              in_valid = 1'b0;
            end
          end else begin
            // junk operands while in_ready is low must be ignored
            in_valid  = 1'b1;
            in_mcand  = W'($urandom);
            in_mplier = W'($urandom);
          end
          #1;
          chk("in_ready", in_ready, (i == int'(NPP) - 1) && pp_ready);
          if (pp_ready) begin
            pd  = int'($signed(pp_data));
            acc = acc + (pd + int'(pp_neg)) * (4 ** i);
          end
          @(posedge clk);
        end
      end
      chk("product", acc, int'($signed(a)) * int'($signed(b)));
      if (!chain) break;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_after", pp_valid, 1'b0);
    chk("idle_ready", in_ready, 1'b1);
  endtask

  task automatic one_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int stall_mode);
    qa.delete(); qb.delete();
    qa.push_back(a); qb.push_back(b);
    run_seq(1'b0, stall_mode);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mcand  = '0;
    in_mplier = '0;
    pp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", pp_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_data", pp_data, 0);
    chk("rst_neg", pp_neg, 1'b0);
    chk("rst_idx", pp_idx, 0);
    chk("rst_last", pp_last, 1'b0);
    rst_n = 1'b1;

    one_txn(8'd3, 8'd7, 0);
    one_txn(8'h80, 8'h80, 0);
    one_txn(8'd5, 8'hFF, 0);
    one_txn(8'd3, 8'd7, 2);
    one_txn(8'h7F, 8'h80, 0);
    one_txn(8'h80, 8'h7F, 1);

    qa.delete(); qb.delete();
    qa.push_back(8'd3); qb.push_back(8'd7);
    qa.push_back(8'd2); qb.push_back(8'd2);
    qa.push_back(8'hC3); qb.push_back(8'h5A);
    run_seq(1'b1, 0);

    // reset while idx2 is on the bus
    @(negedge clk);
    in_mcand = 8'd9; in_mplier = 8'd13; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; pp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_idx", pp_idx, 2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", pp_valid, 1'b0);
    chk("midrst_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("postrst_ready", in_ready, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("no_stale", pp_valid, 1'b0);
    end
    one_txn(8'd11, 8'hF3, 0);

    for (int r = 0; r < 40; r++) begin
      qa.delete(); qb.delete();
      for (int k = 0; k < 3; k++) begin
        qa.push_back(W'($urandom));
        qb.push_back(W'($urandom));
      end
      run_seq(r[0], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
